python_spi_arbiter: RTL
=======================

# python_spi_arbiter

Shares the single `python_spi` register-access port among N requesters, such as the power-up `spi_cmd` sequencer and a host/debug register path. Arbitration is round-robin. A grant stays locked until the master accepts the transaction. Read data returns in issue order, so the block keeps an owner-ID FIFO and routes each returned word back to the requester that issued the read. It sits between the requesters and `python_spi`, in the `clk72` domain.

## Interface
- `N`, 2: number of requesters (2..8)
- `ADDR_BITS`, 9: register address width
- `DATA_BITS`, 16: register data width
- `RFIFO_DEPTH`, 4: maximum outstanding reads (power of 2, ≥2)

- `reset_n`  in  1  asynchronous reset, active low
- `clk`  in  1  single clock
- `s_addr`  in  N×ADDR_BITS  per-requester address
- `s_we`  in  N  per-requester write enable (1 = write, 0 = read)
- `s_wdata`  in  N×DATA_BITS  per-requester write data
- `s_valid`  in  N  per-requester request valid
- `s_ready`  out  N  per-requester accept, one-hot or zero
- `s_rdata`  out  DATA_BITS  returned read data, common to all requesters
- `s_rvalid`  out  N  per-requester read-data strobe, one-hot or zero
- `m_addr`, `m_we`, `m_wdata`, `m_valid`  out  ADDR_BITS/1/DATA_BITS/1  to `python_spi`
- `m_ready`  in  1  from `python_spi`
- `m_rdata`, `m_rvalid`  in  DATA_BITS/1  from `python_spi`
- `busy`  out  1  grant active or reads outstanding
- `err_orphan`  out  1  sticky: `m_rvalid` arrived with the owner FIFO empty

## Operation
- Reset values: `m_valid`=0, `m_addr`/`m_we`/`m_wdata`=0, `s_ready`=0, `s_rvalid`=0, `s_rdata`=0, `busy`=0, `err_orphan`=0, FIFO empty, round-robin pointer=0, state IDLE.
- Eligible requester i: `s_valid[i]`=1 AND (`s_we[i]`=1 OR owner FIFO not full). A read is therefore never granted while the FIFO is full; writes still proceed.
- **IDLE**: if any requester is eligible, grant the first eligible index found scanning from `ptr` upward with wrap. Latch its addr/we/wdata into the `m_*` registers, set `m_valid`=1, go to **ISSUE**.
- **ISSUE**: `m_*` hold stable. When `m_ready`=1:
  - `s_ready[grant]`=1, combinational from `m_ready`, same cycle.
  - If it is a read, push `grant` into the owner FIFO.
  - `m_valid`←0, `ptr`←grant+1 mod N, go to IDLE.
- Requester rule: hold `s_valid` and payload stable until `s_ready`. The arbiter samples the payload only at grant; a requester that changes its payload after grant is in protocol violation.
- Read return: on `m_rvalid`=1 with the FIFO non-empty, pop the owner, register `s_rdata`←`m_rdata`, and pulse `s_rvalid[owner]` for 1 cycle. With the FIFO empty, drop the data and set `err_orphan`=1 until reset.
- A push and a pop in the same cycle are both performed; the count is unchanged.
- `busy` = (state≠IDLE) OR FIFO non-empty.
- Asserting `reset_n` low mid-transaction clears everything immediately. Outstanding reads are lost; a later `m_rvalid` sets `err_orphan`.

## Timing
- Grant latency: eligible `s_valid` sampled at edge t in IDLE → `m_valid`=1 after edge t+1.
- Accept: `s_ready` is asserted in the same cycle as `m_valid`&`m_ready`.
- Back-to-back: the next grant is evaluated in the cycle after acceptance, giving one idle cycle between successive `m_valid` assertions. This is acceptable because SPI transactions take far longer.
- Read return latency: `m_rvalid` at edge t → `s_rvalid`/`s_rdata` valid after edge t+1.
- No combinational path from `s_*` to `m_*`. `m_ready`→`s_ready` is the only combinational path.

## Structure
- Package `python_spi_pkg`:
  - `ADDR_BITS`=9 and `DATA_BITS`=16 defaults.
  - `typedef struct packed {addr; we; wdata} spi_req_t`.
  - `typedef enum logic {IDLE, ISSUE} arb_state_t`.
- Sub-module `python_spi_owner_fifo`: synchronous FIFO with `$clog2(N)`-bit entries, depth `RFIFO_DEPTH`, push/pop/full/empty, and the same `reset_n`/`clk`.
- Round-robin priority selection is a function local to the arbiter.

## Test plan
- **Single write:** req0 writes addr 0x010, data 0x1234; `m_ready` is held high → `m_*`=0x010/1/0x1234 one cycle later, `s_ready[0]` pulses once, `s_rvalid`=0.
- **Fairness:** req0 and req1 hold `s_valid` continuously with writes; `m_ready` stays high → grants alternate 0,1,0,1, with no requester granted twice in a row.
- **Read routing:** req1 reads addr 0x020, then req0 reads addr 0x021; the model returns 0xAAAA then 0x5555 → `s_rvalid[1]` with 0xAAAA, then `s_rvalid[0]` with 0x5555, each one cycle after its `m_rvalid`.
- **FIFO full:** 4 reads are accepted with no return; a 5th read is pending and a write is also pending → the write is granted and the read is stalled. After one `m_rvalid`, the read is granted.
- **Orphan data:** `m_rvalid` arrives with no outstanding read → no `s_rvalid`, `err_orphan`=1 and sticky.
- **Mid-transaction reset:** pull `reset_n` low during ISSUE with `m_ready`=0 → `m_valid`=0 immediately, FIFO empty, `busy`=0. After release, the first request is granted normally.

Source files
------------

// File: rtl/python_spi_pkg.sv
// Shared types for the python_spi register-access path.
package python_spi_pkg;
  localparam int ADDR_BITS = 9;
  localparam int DATA_BITS = 16;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic                 we;
    logic [DATA_BITS-1:0] wdata;
  } spi_req_t;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} arb_state_t;
endpackage

// File: rtl/python_spi_owner_fifo.sv
// Owner-ID FIFO: remembers which requester issued each outstanding read.
module python_spi_owner_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic         reset_n,
  input  logic         clk,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is only accepted when a pop frees a slot this cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/python_spi_arbiter.sv
// Round-robin arbiter sharing the python_spi register port among N requesters,
// with in-order read-data routing through an owner-ID FIFO.
module python_spi_arbiter #(
  parameter int N           = 2,
  parameter int ADDR_BITS   = 9,
  parameter int DATA_BITS   = 16,
  parameter int RFIFO_DEPTH = 4
) (
  input  logic                          reset_n,
  input  logic                          clk,
  input  logic [N-1:0][ADDR_BITS-1:0]   s_addr,
  input  logic [N-1:0]                  s_we,
  input  logic [N-1:0][DATA_BITS-1:0]   s_wdata,
  input  logic [N-1:0]                  s_valid,
  output logic [N-1:0]                  s_ready,
  output logic [DATA_BITS-1:0]          s_rdata,
  output logic [N-1:0]                  s_rvalid,
  output logic [ADDR_BITS-1:0]          m_addr,
  output logic                          m_we,
  output logic [DATA_BITS-1:0]          m_wdata,
  output logic                          m_valid,
  input  logic                          m_ready,
  input  logic [DATA_BITS-1:0]          m_rdata,
  input  logic                          m_rvalid,
  output logic                          busy,
  output logic                          err_orphan
);
  import python_spi_pkg::*;

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // First set bit of req at or above ptr, wrapping at N.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] ptr);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  arb_state_t           state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d, grant_q, grant_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] rdata_q;
  logic [N-1:0]         rvalid_q;
  logic                 err_q;

  logic [N-1:0]  elig;
  logic          push, pop, fifo_full, fifo_empty;
  logic [IW-1:0] owner;

  assign elig = s_valid & (s_we | {N{~fifo_full}});
  assign pop  = m_rvalid & ~fifo_empty;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    s_ready = '0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          grant_d = rr_pick(elig, ptr_q);
          addr_d  = s_addr[grant_d];
          we_d    = s_we[grant_d];
          wdata_d = s_wdata[grant_d];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (m_ready) begin
          s_ready[grant_q] = 1'b1;
          push             = ~we_q;
          ptr_d            = (grant_q == IW'(N-1)) ? '0 : grant_q + IW'(1);
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rvalid_q <= '0;
      if (pop) begin
        rvalid_q[owner] <= 1'b1;
        rdata_q         <= m_rdata;
      end
      // Data with no recorded owner is dropped; flag stays set until reset.
      if (m_rvalid && fifo_empty) err_q <= 1'b1;
    end
  end

  python_spi_owner_fifo #(.W(IW), .DEPTH(RFIFO_DEPTH)) u_owner_fifo (
    .reset_n (reset_n),
    .clk     (clk),
    .push_i  (push),
    .din_i   (grant_q),
    .pop_i   (pop),
    .dout_o  (owner),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m_valid    = (state_q == ISSUE);
  assign m_addr     = addr_q;
  assign m_we       = we_q;
  assign m_wdata    = wdata_q;
  assign s_rdata    = rdata_q;
  assign s_rvalid   = rvalid_q;
  assign busy       = (state_q != IDLE) | ~fifo_empty;
  assign err_orphan = err_q;
endmodule
